// File: rtl/wb_dma_pkg.sv
// Shared definitions for the Wishbone word-copy engine: register map,
// CTRL/STAT bit positions and the copy FSM state encoding.
package wb_dma_pkg;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int CTRL_START    = 0;
    localparam int CTRL_DONE_CLR = 1;
    localparam int CTRL_IE       = 2;
    localparam int CTRL_ABORT    = 3;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_IE    = 2;
    localparam int STAT_ERROR = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        FIN     = 3'd5
    } dma_state_e;

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 pipelined bus bundle, 32-bit data; dat_m is driven by the
// master, dat_s by the slave.
interface wb_if;
    logic [31:0] adr;
    logic [31:0] dat_m;
    logic [31:0] dat_s;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
    logic        cyc;
    logic        ack;
    logic        err;
    logic        stall;

    modport master (
        output adr, dat_m, we, sel, stb, cyc,
        input  dat_s, ack, err, stall
    );

    modport slave (
        input  adr, dat_m, we, sel, stb, cyc,
        output dat_s, ack, err, stall
    );
endinterface

// File: rtl/wb_dma_regs.sv
// Slave-side register file of the copy engine: SRC/DST/LEN configuration,
// CTRL command pulses and STAT readback, with a fixed one-cycle ack.
module wb_dma_regs
    import wb_dma_pkg::*;
#(
    parameter int   LEN_W      = 16,
    parameter logic IRQ_EN_RST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    wb_if.slave              wbs,
    input  logic             busy_i,
    input  logic             lock_i,
    input  logic             done_i,
    input  logic             error_i,
    output logic [31:0]      cfg_src_o,
    output logic [31:0]      cfg_dst_o,
    output logic [LEN_W-1:0] cfg_len_o,
    output logic             start_pulse_o,
    output logic             abort_pulse_o,
    output logic             done_clr_o,
    output logic             ie_o
);

    localparam logic [31:0] LEN_MASK  = 32'((64'd1 << LEN_W) - 64'd1);
    localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

    logic        acc;
    logic        wr_acc;
    logic        ctrl_wr;
    logic [1:0]  reg_sel;
    logic        ack_q;
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;
    logic        ie_q;

    assign acc     = wbs.stb & wbs.cyc;
    assign wr_acc  = acc & wbs.we;
    assign reg_sel = wbs.adr[3:2];
    assign ctrl_wr = wr_acc && (reg_sel == REG_CTRL);

    // Index gi matches the register offset: 0 SRC, 1 DST, 2 LEN.
    // Configuration is frozen while the engine owns it.
    for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
        localparam logic [31:0] MASK = (gi == 2) ? LEN_MASK : ADDR_MASK;
        logic [31:0] val_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                val_q <= '0;
            end else if (wr_acc && !lock_i && (reg_sel == 2'(gi))) begin
                val_q <= wbs.dat_m & MASK;
            end
        end
    end

    assign cfg_src_o = g_cfg[0].val_q;
    assign cfg_dst_o = g_cfg[1].val_q;
    assign cfg_len_o = g_cfg[2].val_q[LEN_W-1:0];

    assign start_pulse_o = ctrl_wr && wbs.dat_m[CTRL_START] && !lock_i;
    assign abort_pulse_o = ctrl_wr && wbs.dat_m[CTRL_ABORT] && busy_i;
    assign done_clr_o    = ctrl_wr && wbs.dat_m[CTRL_DONE_CLR];
    assign ie_o          = ie_q;

    always_comb begin
        rdata_d = '0;
        case (reg_sel)
            REG_SRC: rdata_d = g_cfg[0].val_q;
            REG_DST: rdata_d = g_cfg[1].val_q;
            REG_LEN: rdata_d = g_cfg[2].val_q;
            default: begin
                rdata_d[STAT_BUSY]  = busy_i;
                rdata_d[STAT_DONE]  = done_i;
                rdata_d[STAT_IE]    = ie_q;
                rdata_d[STAT_ERROR] = error_i;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
            ie_q    <= IRQ_EN_RST;
        end else begin
            ack_q   <= acc;
            rdata_q <= (acc && !wbs.we) ? rdata_d : '0;
            if (ctrl_wr) begin
                ie_q <= wbs.dat_m[CTRL_IE];
            end
        end
    end

    assign wbs.ack   = ack_q;
    assign wbs.dat_s = rdata_q;
    assign wbs.err   = 1'b0;
    assign wbs.stall = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, wbs.sel, wbs.adr[31:4], wbs.adr[1:0]};

endmodule

// File: rtl/wb_dma_copy.sv
// Word-granular memory-to-memory copy engine: one Wishbone slave for
// configuration and one Wishbone master doing strict read-then-write pairs.
module wb_dma_copy
    import wb_dma_pkg::*;
#(
    parameter int   LEN_W      = 16,
    parameter logic IRQ_EN_RST = 1'b0
) (
    input  logic clk,
    input  logic rst,
    wb_if.slave  wbs,
    wb_if.master wbm,
    output logic irq
);

    dma_state_e       state_q, state_d;
    logic [31:0]      src_cnt_q, src_cnt_d;
    logic [31:0]      dst_cnt_q, dst_cnt_d;
    logic [31:0]      buf_q, buf_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             abort_q, abort_d;

    logic [31:0]      cfg_src;
    logic [31:0]      cfg_dst;
    logic [LEN_W-1:0] cfg_len;
    logic             start_pulse;
    logic             abort_pulse;
    logic             done_clr;
    logic             ie;

    logic             lock;
    logic             busy;
    logic             abort_hit;

    logic             m_cyc, m_stb, m_we;
    logic [31:0]      m_adr, m_dat;
    logic [3:0]       m_sel;

    // lock covers the FIN cycle too so a start cannot race the done update.
    assign lock      = (state_q != IDLE);
    assign busy      = lock && (state_q != FIN);
    assign abort_hit = abort_q | abort_pulse;

    wb_dma_regs #(
        .LEN_W      (LEN_W),
        .IRQ_EN_RST (IRQ_EN_RST)
    ) u_regs (
        .clk           (clk),
        .rst           (rst),
        .wbs           (wbs),
        .busy_i        (busy),
        .lock_i        (lock),
        .done_i        (done_q),
        .error_i       (error_q),
        .cfg_src_o     (cfg_src),
        .cfg_dst_o     (cfg_dst),
        .cfg_len_o     (cfg_len),
        .start_pulse_o (start_pulse),
        .abort_pulse_o (abort_pulse),
        .done_clr_o    (done_clr),
        .ie_o          (ie)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            src_cnt_q <= '0;
            dst_cnt_q <= '0;
            buf_q     <= '0;
            rem_q     <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_cnt_q <= src_cnt_d;
            dst_cnt_q <= dst_cnt_d;
            buf_q     <= buf_d;
            rem_q     <= rem_d;
            done_q    <= done_d;
            error_q   <= error_d;
            abort_q   <= abort_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        src_cnt_d = src_cnt_q;
        dst_cnt_d = dst_cnt_q;
        buf_d     = buf_q;
        rem_d     = rem_q;
        done_d    = done_q;
        error_d   = error_q;
        abort_d   = abort_q | abort_pulse;
        m_cyc     = 1'b0;
        m_stb     = 1'b0;
        m_we      = 1'b0;
        m_adr     = '0;
        m_dat     = '0;
        m_sel     = 4'h0;

        if (done_clr) begin
            done_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (start_pulse) begin
                    src_cnt_d = cfg_src;
                    dst_cnt_d = cfg_dst;
                    rem_d     = cfg_len;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    state_d   = (cfg_len == '0) ? FIN : RD_REQ;
                end
            end
            RD_REQ: begin
                m_cyc = 1'b1;
                m_stb = 1'b1;
                m_adr = {src_cnt_q[31:2], 2'b00};
                m_sel = 4'hF;
                if (!wbm.stall) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                m_cyc = 1'b1;
                if (wbm.err) begin
                    error_d = 1'b1;
                    state_d = FIN;
                end else if (wbm.ack) begin
                    buf_d = wbm.dat_s;
                    if (abort_hit) begin
                        error_d = 1'b1;
                        state_d = FIN;
                    end else begin
                        state_d = WR_REQ;
                    end
                end
            end
            WR_REQ: begin
                m_cyc = 1'b1;
                m_stb = 1'b1;
                m_we  = 1'b1;
                m_adr = dst_cnt_q;
                m_dat = buf_q;
                m_sel = 4'hF;
                if (!wbm.stall) begin
                    state_d = WR_WAIT;
                end
            end
            WR_WAIT: begin
                m_cyc = 1'b1;
                if (wbm.err) begin
                    error_d = 1'b1;
                    state_d = FIN;
                end else if (wbm.ack) begin
                    src_cnt_d = src_cnt_q + 32'd4;
                    dst_cnt_d = dst_cnt_q + 32'd4;
                    rem_d     = rem_q - LEN_W'(1);
                    if (abort_hit) begin
                        error_d = 1'b1;
                    end
                    state_d = (rem_q == LEN_W'(1) || abort_hit) ? FIN : RD_REQ;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                abort_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wbm.cyc   = m_cyc;
    assign wbm.stb   = m_stb;
    assign wbm.we    = m_we;
    assign wbm.adr   = m_adr;
    assign wbm.dat_m = m_dat;
    assign wbm.sel   = m_sel;

    assign irq = done_q & ie;

endmodule

// File: tb/tb_wb_dma_copy.sv
// Scoreboard bench for wb_dma_copy: a register-port driver, a memory-model
// responder on the copy port, and monitors popping expected-response queues.
module tb_wb_dma_copy;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq;

    always #5 clk = ~clk;

    wb_if wbs_if ();
    wb_if wbm_if ();

    wb_dma_copy #(
        .LEN_W      (16),
        .IRQ_EN_RST (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .wbs (wbs_if),
        .wbm (wbm_if),
        .irq (irq)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    typedef struct packed { logic chk; logic [31:0] data; } s_exp_t;
    typedef struct packed { logic we; logic [31:0] adr; logic [31:0] dat; } m_exp_t;

    s_exp_t s_exp_q[$];
    m_exp_t m_exp_q[$];

    logic [31:0] mem [logic [31:0]];

    // memory-model knobs and observation counters
    int     stall_max = 0;
    int     ack_min   = 0;
    int     ack_max   = 0;
    int     err_on_rd = 0;
    int     rd_cnt    = 0;
    int     rd_acks   = 0;
    int     n_txn     = 0;
    logic   pend      = 1'b0;
    m_exp_t cur;

    task automatic push_m(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        m_exp_t e;
        e.we  = we;
        e.adr = adr;
        e.dat = dat;
        m_exp_q.push_back(e);
    endtask

    // Register-port monitor.
    initial begin
        s_exp_t e;
        forever begin
            @(negedge clk);
            if (wbs_if.ack === 1'b1) begin
                check("wbs_ack_expected", 32'(s_exp_q.size() != 0), 32'd1);
                if (s_exp_q.size() != 0) begin
                    e = s_exp_q.pop_front();
                    if (e.chk) check("wbs_rdata", wbs_if.dat_s, e.data);
                end
            end
        end
    end

    // Copy-port memory model and monitor; decisions at negedge apply to the next posedge.
    initial begin
        m_exp_t e;
        int     dly;
        int     stall_cnt;
        logic   prev_stalled;
        logic   pend_before;
        dly = 0;
        stall_cnt = 0;
        prev_stalled = 1'b0;
        wbm_if.ack   = 1'b0;
        wbm_if.err   = 1'b0;
        wbm_if.stall = 1'b0;
        wbm_if.dat_s = '0;
        forever begin
            @(negedge clk);
            wbm_if.ack = 1'b0;
            wbm_if.err = 1'b0;
            if (rst) begin
                pend = 1'b0;
                prev_stalled = 1'b0;
                stall_cnt = 0;
                wbm_if.stall = 1'b0;
            end else begin
                pend_before = pend;
                if (prev_stalled) check("wbm_stb_held", 32'(wbm_if.cyc & wbm_if.stb), 32'd1);
                if (pend) begin
                    if (dly == 0) begin
                        pend = 1'b0;
                        if (!cur.we) begin
                            rd_cnt++;
                            if (rd_cnt == err_on_rd) begin
                                wbm_if.err = 1'b1;
                            end else begin
                                wbm_if.ack   = 1'b1;
                                wbm_if.dat_s = mem.exists(cur.adr) ? mem[cur.adr] : 32'h0;
                                rd_acks++;
                            end
                        end else begin
                            mem[cur.adr] = cur.dat;
                            wbm_if.ack = 1'b1;
                        end
                    end else begin
                        dly--;
                    end
                end
                if (stall_cnt > 0) begin
                    wbm_if.stall = 1'b1;
                    stall_cnt--;
                end else begin
                    wbm_if.stall = 1'b0;
                end
                if (wbm_if.cyc && wbm_if.stb && !wbm_if.stall) begin
                    check("wbm_one_outstanding", 32'(pend_before), 32'd0);
                    check("wbm_txn_expected", 32'(m_exp_q.size() != 0), 32'd1);
                    check("wbm_sel", 32'(wbm_if.sel), 32'hF);
                    if (m_exp_q.size() != 0) begin
                        e = m_exp_q.pop_front();
                        check("wbm_we", 32'(wbm_if.we), 32'(e.we));
                        check("wbm_adr", wbm_if.adr, e.adr);
                        if (e.we) check("wbm_wdata", wbm_if.dat_m, e.dat);
                    end
                    cur.we  = wbm_if.we;
                    cur.adr = wbm_if.adr;
                    cur.dat = wbm_if.dat_m;
                    pend = 1'b1;
                    dly = int'($urandom_range(ack_max, ack_min));
                    stall_cnt = int'($urandom_range(stall_max, 0));
                    n_txn++;
                    $display("wbm %s adr=0x%08h dat=0x%08h", wbm_if.we ? "WR" : "RD", wbm_if.adr, wbm_if.dat_m);
                end
                prev_stalled = wbm_if.cyc & wbm_if.stb & wbm_if.stall;
            end
        end
    end

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        s_exp_t e;
        e.chk = 1'b0;
        e.data = '0;
        s_exp_q.push_back(e);
        wbs_if.adr = a; wbs_if.dat_m = d; wbs_if.we = 1'b1;
        wbs_if.sel = 4'hF; wbs_if.cyc = 1'b1; wbs_if.stb = 1'b1;
        @(negedge clk);
        wbs_if.stb = 1'b0; wbs_if.cyc = 1'b0; wbs_if.we = 1'b0;
        check("wbs_ack_latency", 32'(wbs_if.ack), 32'd1);
        $display("wbs WR adr=0x%02h dat=0x%08h", a[7:0], d);
    endtask

    task automatic wb_read(input logic [31:0] a, input logic [31:0] exp);
        s_exp_t e;
        e.chk = 1'b1;
        e.data = exp;
        s_exp_q.push_back(e);
        wbs_if.adr = a; wbs_if.we = 1'b0;
        wbs_if.sel = 4'hF; wbs_if.cyc = 1'b1; wbs_if.stb = 1'b1;
        @(negedge clk);
        wbs_if.stb = 1'b0; wbs_if.cyc = 1'b0;
        check("wbs_ack_latency", 32'(wbs_if.ack), 32'd1);
        $display("wbs RD adr=0x%02h exp=0x%08h got=0x%08h", a[7:0], exp, wbs_if.dat_s);
    endtask

    task automatic wait_irq(input string name, input int budget);
        int n;
        n = 0;
        while (irq !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(irq), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n;
        wbs_if.adr = '0; wbs_if.dat_m = '0; wbs_if.we = 1'b0;
        wbs_if.sel = 4'h0; wbs_if.stb = 1'b0; wbs_if.cyc = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_wbm_cyc", 32'(wbm_if.cyc), 32'd0);
        check("rst_wbm_stb", 32'(wbm_if.stb), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_wbs_ack", 32'(wbs_if.ack), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        wb_read(32'hC, 32'h0);

        // Register file: low address bits masked, LEN zero-extended, ie readback.
        wb_write(32'h0, 32'h0000_0103);
        wb_write(32'h4, 32'h0000_0202);
        wb_write(32'h8, 32'hFFFF_0003);
        wb_write(32'hC, 32'h0000_0004);
        wb_read(32'h0, 32'h0000_0100);
        wb_read(32'h4, 32'h0000_0200);
        wb_read(32'h8, 32'h0000_0003);
        wb_read(32'hC, 32'h0000_0004);

        // Plain copy of four words, zero-wait responder.
        for (int i = 0; i < 8; i++) mem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
        for (int i = 0; i < 4; i++) mem[32'h200 + 32'(4 * i)] = 32'hDEAD_0000;
        wb_write(32'h8, 32'd4);
        for (int i = 0; i < 4; i++) begin
            push_m(1'b0, 32'h100 + 32'(4 * i), 32'h0);
            push_m(1'b1, 32'h200 + 32'(4 * i), 32'hA0 + 32'(i));
        end
        t0 = n_txn;
        wb_write(32'hC, 32'h5);
        wait_irq("copy_irq", 200);
        wb_read(32'hC, 32'h6);
        for (int i = 0; i < 4; i++) check("copy_dst", mem[32'h200 + 32'(4 * i)], 32'hA0 + 32'(i));
        check("copy_txn_count", 32'(n_txn - t0), 32'd8);
        check("copy_exp_left", 32'(m_exp_q.size()), 32'd0);

        // LEN=0: no bus activity, done two cycles after the start write.
        wb_write(32'h8, 32'd0);
        t0 = n_txn;
        wb_write(32'hC, 32'h5);
        check("len0_irq_c1", 32'(irq), 32'd0);
        check("len0_cyc_c1", 32'(wbm_if.cyc), 32'd0);
        @(negedge clk);
        check("len0_irq_c2", 32'(irq), 32'd1);
        check("len0_cyc_c2", 32'(wbm_if.cyc), 32'd0);
        repeat (3) @(negedge clk);
        check("len0_txn_count", 32'(n_txn - t0), 32'd0);
        wb_read(32'hC, 32'h6);

        // Sixteen words under random stall and ack delay.
        stall_max = 5; ack_min = 0; ack_max = 3;
        for (int i = 0; i < 16; i++) begin
            mem[32'h1000 + 32'(4 * i)] = 32'h5000_0000 + 32'(i) * 32'h111;
            mem[32'h2000 + 32'(4 * i)] = 32'h0;
            push_m(1'b0, 32'h1000 + 32'(4 * i), 32'h0);
            push_m(1'b1, 32'h2000 + 32'(4 * i), 32'h5000_0000 + 32'(i) * 32'h111);
        end
        wb_write(32'h0, 32'h1000);
        wb_write(32'h4, 32'h2000);
        wb_write(32'h8, 32'd16);
        wb_write(32'hC, 32'h5);
        wait_irq("stall_irq", 1500);
        wb_read(32'hC, 32'h6);
        for (int i = 0; i < 16; i++)
            check("stall_dst", mem[32'h2000 + 32'(4 * i)], 32'h5000_0000 + 32'(i) * 32'h111);
        check("stall_exp_left", 32'(m_exp_q.size()), 32'd0);
        stall_max = 0; ack_max = 0;

        // Bus error on the second read: one word written, error flagged.
        rd_cnt = 0; err_on_rd = 2;
        for (int i = 0; i < 4; i++) mem[32'h300 + 32'(4 * i)] = 32'h0;
        wb_write(32'h0, 32'h100);
        wb_write(32'h4, 32'h300);
        wb_write(32'h8, 32'd4);
        push_m(1'b0, 32'h100, 32'h0);
        push_m(1'b1, 32'h300, 32'hA0);
        push_m(1'b0, 32'h104, 32'h0);
        t0 = n_txn;
        wb_write(32'hC, 32'h5);
        wait_irq("err_irq", 200);
        check("err_cyc_after_fin", 32'(wbm_if.cyc), 32'd0);
        err_on_rd = 0;
        wb_read(32'hC, 32'hE);
        check("err_dst0", mem[32'h300], 32'hA0);
        check("err_dst1", mem[32'h304], 32'h0);
        check("err_txn_count", 32'(n_txn - t0), 32'd3);
        check("err_exp_left", 32'(m_exp_q.size()), 32'd0);

        // Abort while the second word's write is in flight.
        ack_min = 3; ack_max = 3; rd_acks = 0;
        for (int i = 0; i < 8; i++) mem[32'h400 + 32'(4 * i)] = 32'h1111_1111;
        wb_write(32'h4, 32'h400);
        wb_write(32'h8, 32'd8);
        push_m(1'b0, 32'h100, 32'h0);
        push_m(1'b1, 32'h400, 32'hA0);
        push_m(1'b0, 32'h104, 32'h0);
        push_m(1'b1, 32'h404, 32'hA1);
        wb_write(32'hC, 32'h5);
        n = 0;
        while (rd_acks < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_saw_rd2", 32'(rd_acks >= 2), 32'd1);
        @(negedge clk);
        wb_write(32'hC, 32'hC);
        wait_irq("abort_irq", 200);
        wb_read(32'hC, 32'hE);
        check("abort_dst0", mem[32'h400], 32'hA0);
        check("abort_dst1", mem[32'h404], 32'hA1);
        for (int i = 2; i < 8; i++) check("abort_dst_untouched", mem[32'h400 + 32'(4 * i)], 32'h1111_1111);
        check("abort_exp_left", 32'(m_exp_q.size()), 32'd0);

        // done_clr leaves error; abort while idle changes nothing.
        wb_write(32'hC, 32'h6);
        wb_read(32'hC, 32'hC);
        t0 = n_txn;
        wb_write(32'hC, 32'hC);
        repeat (3) @(negedge clk);
        wb_read(32'hC, 32'hC);
        check("idle_abort_txn", 32'(n_txn - t0), 32'd0);

        // Reset during RD_WAIT.
        wb_write(32'h4, 32'h500);
        wb_write(32'h8, 32'd4);
        push_m(1'b0, 32'h100, 32'h0);
        wb_write(32'hC, 32'h5);
        n = 0;
        while (!(pend && !cur.we) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_saw_rd_pending", 32'(pend), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_cyc", 32'(wbm_if.cyc), 32'd0);
        check("rst_mid_stb", 32'(wbm_if.stb), 32'd0);
        rst = 1'b0;
        m_exp_q.delete();
        ack_min = 0; ack_max = 0;
        @(negedge clk);
        check("rst_mid_irq", 32'(irq), 32'd0);
        wb_read(32'hC, 32'h0);

        repeat (5) @(negedge clk);
        check("wbs_exp_left", 32'(s_exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
